// File: rtl/rsp_pkt_sched.sv
// Packet-aware round-robin scheduler: four response FIFOs share one
// registered NOC output, one whole packet per grant.
module rsp_pkt_sched #(
  parameter int NPORT    = 4,
  parameter int WR_BODY  = 5,
  parameter int MSG_BODY = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fifo_empty,
  input  logic [35:0] fifo_data,
  output logic [3:0]  fifo_rd_en,
  output logic        noc_from_dev_ctl,
  output logic [7:0]  noc_from_dev_data,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        hdr_err,
  output logic        underrun_err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_PRE,
    S_RD_AL,
    S_BODY
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  own_q, own_d;
  logic [3:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        gap_q, gap_d;
  logic        ctl_q, ctl_d;
  logic [7:0]  data_q, data_d;
  logic        hdr_q, hdr_d;
  logic        und_q, und_d;

  logic [3:0]  rd_en;
  logic [3:0]  hctl;
  logic [7:0]  hdat [NPORT];
  logic [3:0]  vhdr;
  logic [3:0]  purge;
  logic        found;
  logic [1:0]  sel;
  logic [1:0]  idx;
  logic [1:0]  pidx;
  logic        hdr_set;
  logic        und_set;
  logic        pkt_end;

  always_comb begin
    hctl  = '0;
    vhdr  = '0;
    purge = '0;
    for (int i = 0; i < NPORT; i++) begin
      hctl[i] = fifo_data[9*i+8];
      hdat[i] = fifo_data[9*i +: 8];
      vhdr[i] = !fifo_empty[i] && hctl[i] && (hdat[i] != 8'h00) &&
                (hdat[i][2:0] inside {3'b011, 3'b100, 3'b101});
      purge[i] = !fifo_empty[i] && !vhdr[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    own_d   = own_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    gap_d   = 1'b0;
    ctl_d   = 1'b1;
    data_d  = 8'h00;
    rd_en   = '0;
    hdr_set = 1'b0;
    und_set = 1'b0;
    pkt_end = 1'b0;
    found   = 1'b0;
    sel     = '0;
    idx     = '0;
    pidx    = '0;

    unique case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NPORT; k++) begin
          idx = rr_q + 2'(k);
          if (!found && vhdr[idx]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        for (int k = NPORT - 1; k >= 0; k--) begin
          if (purge[k]) pidx = 2'(k);
        end
        // The cycle right after a packet end never grants, which
        // leaves one idle output word between packets.
        if (!gap_q && found) begin
          rd_en[sel] = 1'b1;
          ctl_d      = hctl[sel];
          data_d     = hdat[sel];
          own_d      = sel;
          grant_d    = 4'b0001 << sel;
          busy_d     = 1'b1;
          unique case (hdat[sel][2:0])
            3'b011: begin
              cnt_d   = 9'd2;
              state_d = S_RD_PRE;
            end
            3'b100: begin
              cnt_d   = 9'(WR_BODY);
              state_d = S_BODY;
            end
            default: begin
              cnt_d   = 9'(MSG_BODY);
              state_d = S_BODY;
            end
          endcase
        end else if (|purge) begin
          rd_en[pidx] = 1'b1;
          hdr_set     = !(hctl[pidx] && hdat[pidx] == 8'h00);
        end
      end
      default: begin
        if (fifo_empty[own_q]) begin
          und_set = 1'b1;
        end else begin
          rd_en[own_q] = 1'b1;
          ctl_d        = hctl[own_q];
          data_d       = hdat[own_q];
          if (state_q == S_RD_AL) begin
            cnt_d = {1'b0, hdat[own_q]};
            if (hdat[own_q] == 8'h00) pkt_end = 1'b1;
            else state_d = S_BODY;
          end else begin
            cnt_d = cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              if (state_q == S_RD_PRE) state_d = S_RD_AL;
              else pkt_end = 1'b1;
            end
          end
        end
      end
    endcase

    if (pkt_end) begin
      state_d = S_IDLE;
      grant_d = '0;
      busy_d  = 1'b0;
      rr_d    = own_q + 2'd1;
      gap_d   = 1'b1;
    end

    hdr_d = hdr_set || (hdr_q && !err_clr);
    und_d = und_set || (und_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      own_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      gap_q   <= 1'b0;
      ctl_q   <= 1'b1;
      data_q  <= 8'h00;
      hdr_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      gap_q   <= gap_d;
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      hdr_q   <= hdr_d;
      und_q   <= und_d;
    end
  end

  assign fifo_rd_en        = reset ? 4'b0000 : rd_en;
  assign noc_from_dev_ctl  = ctl_q;
  assign noc_from_dev_data = data_q;
  assign grant             = grant_q;
  assign busy              = busy_q;
  assign hdr_err           = hdr_q;
  assign underrun_err      = und_q;

endmodule

// File: tb/tb_rsp_pkt_sched.sv
// Directed bench for rsp_pkt_sched: FWFT FIFO models feed the DUT and
// per-cycle expectation tables are checked at the falling edge.
module tb_rsp_pkt_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  fifo_empty;
  logic [35:0] fifo_data;
  logic [3:0]  fifo_rd_en;
  logic        noc_from_dev_ctl;
  logic [7:0]  noc_from_dev_data;
  logic [3:0]  grant;
  logic        busy;
  logic        hdr_err;
  logic        underrun_err;
  logic        err_clr;

  always #5 clk = ~clk;

  rsp_pkt_sched dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_data         (fifo_data),
    .fifo_rd_en        (fifo_rd_en),
    .noc_from_dev_ctl  (noc_from_dev_ctl),
    .noc_from_dev_data (noc_from_dev_data),
    .grant             (grant),
    .busy              (busy),
    .hdr_err           (hdr_err),
    .underrun_err      (underrun_err),
    .err_clr           (err_clr)
  );

  logic [8:0] mem [4][512];
  int         wr_ptr [4];
  int         rd_ptr [4];
  logic [3:0] flush;

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i]       = (rd_ptr[i] == wr_ptr[i]);
      fifo_data[9*i +: 9] = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush[i]) rd_ptr[i] <= wr_ptr[i];
      else if (fifo_rd_en[i] && rd_ptr[i] != wr_ptr[i])
        rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  typedef struct {
    logic [3:0] rd;
    logic       ctl;
    logic [7:0] data;
    logic [3:0] gnt;
    logic       bsy;
  } vec_t;

  vec_t       vq[$];
  logic       pend_ctl;
  logic [7:0] pend_data;
  int         n_tests;
  int         n_fail;

  task automatic push(input int p, input logic [8:0] w);
    mem[p][wr_ptr[p]] = w;
    wr_ptr[p] = wr_ptr[p] + 1;
  endtask

  task automatic push_pkt(input int p, input logic [8:0] hdr,
                          input int nb, input logic [7:0] base,
                          output int s);
    s = wr_ptr[p];
    push(p, hdr);
    for (int k = 0; k < nb; k++) push(p, {1'b0, base + 8'(k)});
  endtask

  // Output seen in a cycle is whatever was popped the cycle before.
  task automatic add(input logic [3:0] rd, input logic popped,
                     input logic [8:0] w, input logic [3:0] gnt,
                     input logic bsy);
    vq.push_back('{rd, pend_ctl, pend_data, gnt, bsy});
    if (popped) {pend_ctl, pend_data} = w;
    else {pend_ctl, pend_data} = 9'h100;
  endtask

  task automatic add_idle();
    add(4'b0000, 1'b0, 9'h000, 4'b0000, 1'b0);
  endtask

  task automatic add_pkt(input int p, input int s, input int n);
    logic [3:0] g;
    g = 4'b0001 << p;
    for (int k = 0; k < n; k++)
      add(g, 1'b1, mem[p][s+k], (k == 0) ? 4'b0000 : g, k != 0);
  endtask

  task automatic run_table(input string name);
    foreach (vq[i]) begin
      #1;
      n_tests++;
      if ({fifo_rd_en, noc_from_dev_ctl, noc_from_dev_data, grant, busy} !==
          {vq[i].rd, vq[i].ctl, vq[i].data, vq[i].gnt, vq[i].bsy}) begin
        n_fail++;
        $display("FAIL %s[%0d]: got rd=%b ctl=%b data=%h gnt=%b busy=%b, want rd=%b ctl=%b data=%h gnt=%b busy=%b",
                 name, i, fifo_rd_en, noc_from_dev_ctl, noc_from_dev_data,
                 grant, busy, vq[i].rd, vq[i].ctl, vq[i].data,
                 vq[i].gnt, vq[i].bsy);
      end
      @(negedge clk);
    end
    vq.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  int s0, s1, s2, s3, sb0, sb3;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    err_clr   = 1'b0;
    flush     = '0;
    pend_ctl  = 1'b1;
    pend_data = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", 32'(noc_from_dev_ctl), 32'd1);
    chk("rst_data", 32'(noc_from_dev_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_grant_busy", 32'({grant, busy}), 32'd0);
    chk("rst_errs", 32'({hdr_err, underrun_err}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Write response alone on FIFO2.
    push_pkt(2, 9'h104, 5, 8'h21, s2);
    add_pkt(2, s2, 6);
    add_idle();
    add_idle();
    run_table("wr_fifo2");

    // Pointer now at 3: FIFO3 wins over FIFO0.
    push_pkt(0, 9'h105, 6, 8'h01, s0);
    push_pkt(3, 9'h105, 6, 8'h31, s3);
    add_pkt(3, s3, 7);
    add_idle();
    add_pkt(0, s0, 7);
    add_idle();
    add_idle();
    run_table("rr_ptr3");

    // Fresh reset, all four message headers at once.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push_pkt(0, 9'h105, 6, 8'h41, s0);
    push_pkt(1, 9'h105, 6, 8'h51, s1);
    push_pkt(2, 9'h105, 6, 8'h61, s2);
    push_pkt(3, 9'h105, 6, 8'h71, s3);
    push_pkt(0, 9'h105, 6, 8'h81, sb0);
    push_pkt(3, 9'h105, 6, 8'h91, sb3);
    add_pkt(0, s0, 7);
    add_idle();
    add_pkt(1, s1, 7);
    add_idle();
    add_pkt(2, s2, 7);
    add_idle();
    add_pkt(3, s3, 7);
    add_idle();
    add_pkt(0, sb0, 7);
    add_idle();
    add_pkt(3, sb3, 7);
    add_idle();
    add_idle();
    run_table("msg_all4");

    // Read responses on FIFO1: AL=4 then AL=0.
    s1 = wr_ptr[1];
    push(1, 9'h103);
    push(1, 9'h0aa);
    push(1, 9'h0bb);
    push(1, 9'h004);
    for (int k = 0; k < 4; k++) push(1, 9'h0d0 + 9'(k));
    s2 = wr_ptr[1];
    push(1, 9'h103);
    push(1, 9'h0a1);
    push(1, 9'h0b1);
    push(1, 9'h000);
    add_pkt(1, s1, 8);
    add_idle();
    add_pkt(1, s2, 4);
    add_idle();
    add_idle();
    run_table("rd_fifo1");

    // Bad head on FIFO0 waits behind FIFO1's write, then is dropped.
    push(0, 9'h107);
    push_pkt(1, 9'h104, 5, 8'hc1, s1);
    add_pkt(1, s1, 6);
    add(4'b0001, 1'b0, 9'h000, 4'b0000, 1'b0);
    add_idle();
    run_table("bad_hdr");
    #1;
    chk("hdr_err_set", 32'(hdr_err), 32'd1);
    chk("und_err_clean", 32'(underrun_err), 32'd0);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("hdr_err_clr", 32'(hdr_err), 32'd0);
    @(negedge clk);

    // Underrun: FIFO2 runs dry after 2 of 5 body words.
    push_pkt(2, 9'h104, 2, 8'he1, s2);
    add_pkt(2, s2, 3);
    add(4'b0000, 1'b0, 9'h000, 4'b0100, 1'b1);
    add(4'b0000, 1'b0, 9'h000, 4'b0100, 1'b1);
    run_table("undr_a");
    #1;
    chk("und_err_set", 32'(underrun_err), 32'd1);
    chk("und_grant_held", 32'(grant), 32'h4);
    s3 = wr_ptr[2];
    push(2, 9'h0e3);
    push(2, 9'h1e4);
    push(2, 9'h0e5);
    for (int k = 0; k < 3; k++)
      add(4'b0100, 1'b1, mem[2][s3+k], 4'b0100, 1'b1);
    add_idle();
    add_idle();
    run_table("undr_b");
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("und_err_clr", 32'(underrun_err), 32'd0);
    @(negedge clk);

    // Reset during a FIFO3 message body.
    push_pkt(3, 9'h105, 6, 8'hf1, s3);
    add_pkt(3, s3, 3);
    run_table("pre_rst");
    reset = 1'b1;
    flush = 4'b1000;
    #1;
    chk("rst_mid_no_pop", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    flush = '0;
    #1;
    chk("rst_mid_out",
        32'({fifo_rd_en, noc_from_dev_ctl, noc_from_dev_data, grant, busy}),
        32'({4'b0000, 1'b1, 8'h00, 4'b0000, 1'b0}));
    pend_ctl  = 1'b1;
    pend_data = 8'h00;
    push_pkt(1, 9'h105, 6, 8'ha1, s1);
    push_pkt(3, 9'h105, 6, 8'hb1, s3);
    add_pkt(1, s1, 7);
    add_idle();
    add_pkt(3, s3, 7);
    add_idle();
    add_idle();
    run_table("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
